// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared helpers for the 1-to-N stream demultiplexer
package demux_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int CNT_MAX_W = 32;

  // All-ones value for a counter of width w, used as the saturation ceiling.
  function automatic logic [CNT_MAX_W-1:0] cnt_max(input int w);
    if (w >= CNT_MAX_W) return '1;
    return (CNT_MAX_W'(1) << w) - CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output holding register with valid/ready handshake
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
);

  // A draining slot can be refilled on the same edge.
  assign can_accept = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/demux_1ton_stream.sv
// rtl/demux_1ton_stream.sv - 1-to-NCH stream demux with broadcast and bad-select counting
module demux_1ton_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = clog2_min1(NCH),
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 err_pulse,
  output logic [CNTW-1:0]      err_cnt
);

  localparam logic [CNT_MAX_W-1:0] CNT_MAX_FULL = cnt_max(CNTW);
  localparam logic [CNTW-1:0]      CNT_MAX      = CNT_MAX_FULL[CNTW-1:0];

  logic [NCH-1:0] can_accept;
  logic [NCH-1:0] load;
  logic           sel_ok;
  logic           sel_can;
  logic           in_fire;
  logic           bad_fire;

  always_comb begin
    sel_ok  = 1'b0;
    sel_can = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (in_sel == SELW'(i)) begin
        sel_ok  = 1'b1;
        sel_can = can_accept[i];
      end
    end
  end

  // A bad select is always accepted so the producer never deadlocks on it.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (in_bcast)     in_ready = &can_accept;
      else if (!sel_ok) in_ready = 1'b1;
      else              in_ready = sel_can;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign bad_fire = in_fire && !in_bcast && !sel_ok;

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    assign load[g] = in_fire && (in_bcast || (in_sel == SELW'(g)));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[g]),
      .load_data  (in_data),
      .ready      (out_ready[g]),
      .valid      (out_valid[g]),
      .data       (out_data[g*WIDTH +: WIDTH]),
      .can_accept (can_accept[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= bad_fire;
      if (bad_fire && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_1ton_stream.sv
// tb/tb_demux_1ton_stream.sv - self-checking bench for demux_1ton_stream
module tb_demux_1ton_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v4, bc4, rdy4, ep4;
  logic [1:0]  sel4;
  logic [3:0]  d4, ordy4, ov4;
  logic [15:0] od4;
  logic [7:0]  ec4;

  logic        v3, bc3, rdy3, ep3;
  logic [1:0]  sel3, ec3;
  logic [3:0]  d3;
  logic [2:0]  ordy3, ov3;
  logic [11:0] od3;

  demux_1ton_stream #(.WIDTH(4), .NCH(4), .SELW(2), .CNTW(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .in_sel(sel4), .in_bcast(bc4), .out_valid(ov4), .out_ready(ordy4),
    .out_data(od4), .err_pulse(ep4), .err_cnt(ec4)
  );

  demux_1ton_stream #(.WIDTH(4), .NCH(3), .SELW(2), .CNTW(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .in_sel(sel3), .in_bcast(bc3), .out_valid(ov3), .out_ready(ordy3),
    .out_data(od3), .err_pulse(ep3), .err_cnt(ec3)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the 4-channel instance: one word (or nothing) per channel.
  logic [3:0] m_full;
  logic [3:0] m_word [4];
  logic       m_pulse;
  logic [7:0] m_cnt;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       bc;
    logic [3:0] d;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_vld;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    logic all_free;
    if (rst) return 1'b0;
    all_free = 1'b1;
    for (int i = 0; i < 4; i++)
      if (m_full[i] && !ordy4[i]) all_free = 1'b0;
    if (bc4) return all_free;
    return !m_full[sel4] || ordy4[sel4];
  endfunction

  function automatic logic [15:0] model_data();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m_full[i]) r[i*4 +: 4] = m_word[i];
    return r;
  endfunction

  task automatic model_step();
    logic take;
    take = v4 && model_ready();
    if (rst) begin
      m_full = '0; m_pulse = 1'b0; m_cnt = '0;
      for (int i = 0; i < 4; i++) m_word[i] = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (take && (bc4 || int'(sel4) == i)) begin
          m_full[i] = 1'b1; m_word[i] = d4;
        end else if (m_full[i] && ordy4[i]) begin
          m_full[i] = 1'b0; m_word[i] = '0;
        end
      end
      m_pulse = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [1:0] sel, input logic bc,
                        input logic [3:0] d, input logic [3:0] ordy);
    v4 = v; sel4 = sel; bc4 = bc; d4 = d; ordy4 = ordy;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".in_ready"},  32'(rdy4), 32'(model_ready()));
    chk({tag, ".out_valid"}, 32'(ov4),  32'(m_full));
    chk({tag, ".out_data"},  32'(od4),  32'(model_data()));
    chk({tag, ".err_pulse"}, 32'(ep4),  32'(m_pulse));
    chk({tag, ".err_cnt"},   32'(ec4),  32'(m_cnt));
  endtask

  function automatic void add(input logic v, input logic [1:0] sel, input logic bc,
                              input logic [3:0] d, input logic [3:0] ordy, input logic er,
                              input logic [3:0] ev, input logic [15:0] ed);
    vec_t t;
    t.v = v; t.sel = sel; t.bc = bc; t.d = d; t.ordy = ordy;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_data = ed;
    tbl.push_back(t);
  endfunction

  initial begin
    // basic routing
    add(1, 2, 0, 4'hA, 4'hF, 1, 4'b0100, 16'h0A00);
    add(0, 0, 0, 4'h0, 4'hF, 1, 4'b0000, 16'h0000);
    // back-to-back on channel 3
    for (int k = 0; k < 8; k++)
      add(1, 3, 0, 4'(k), 4'b1000, 1, 4'b1000, {4'(k), 12'h000});
    add(0, 3, 0, 4'h0, 4'b1000, 1, 4'b0000, 16'h0000);
    // broadcast waits for the full slot 2
    add(1, 2, 0, 4'h9, 4'b1011, 1, 4'b0100, 16'h0900);
    add(1, 0, 1, 4'hC, 4'b1011, 0, 4'b0100, 16'h0900);
    add(1, 3, 1, 4'hC, 4'b1011, 0, 4'b0100, 16'h0900);
    add(1, 0, 1, 4'hC, 4'b1111, 1, 4'b1111, 16'hCCCC);
    add(0, 0, 0, 4'h0, 4'b1111, 1, 4'b0000, 16'h0000);
    // stall isolation on channel 1
    add(1, 1, 0, 4'h3, 4'b1101, 1, 4'b0010, 16'h0030);
    add(1, 1, 0, 4'h5, 4'b1101, 0, 4'b0010, 16'h0030);
    add(1, 1, 0, 4'h5, 4'b1111, 1, 4'b0010, 16'h0050);
    add(1, 0, 0, 4'h7, 4'b1101, 1, 4'b0011, 16'h0057);
    add(0, 0, 0, 4'h0, 4'b1111, 1, 4'b0000, 16'h0000);

    rst = 1'b1;
    drive4(1, 2, 0, 4'h5, 4'hF);
    v3 = 0; sel3 = 0; bc3 = 0; d3 = 0; ordy3 = 0;
    #1;
    chk("rst.in_ready", 32'(rdy4), 32'(0));
    tick();
    tick();
    chk("rst.out_valid", 32'(ov4), 32'(0));
    chk("rst.out_data",  32'(od4), 32'(0));
    chk("rst.err_pulse", 32'(ep4), 32'(0));
    chk("rst.err_cnt",   32'(ec4), 32'(0));
    chk("rst.in_ready3", 32'(rdy3), 32'(0));
    rst = 1'b0;
    drive4(0, 0, 0, 4'h0, 4'hF);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive4(tbl[i].v, tbl[i].sel, tbl[i].bc, tbl[i].d, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d.in_ready", i), 32'(rdy4), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("tbl%0d.out_valid", i), 32'(ov4), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d.out_data", i),  32'(od4), 32'(tbl[i].exp_data));
    end

    // bad select on the 3-channel instance, counter saturates at 3
    v3 = 1; sel3 = 3; d3 = 4'hB; ordy3 = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("bad%0d.in_ready", k), 32'(rdy3), 32'(1));
      tick();
      chk($sformatf("bad%0d.out_valid", k), 32'(ov3), 32'(0));
      chk($sformatf("bad%0d.err_pulse", k), 32'(ep3), 32'(1));
      chk($sformatf("bad%0d.err_cnt", k),   32'(ec3), 32'(k));
    end
    tick();
    chk("bad_sat.err_cnt", 32'(ec3), 32'(3));
    v3 = 0;
    tick();
    chk("bad_idle.err_pulse", 32'(ep3), 32'(0));
    chk("bad_idle.err_cnt",   32'(ec3), 32'(3));
    v3 = 1; sel3 = 2; d3 = 4'h6;
    #1;
    chk("good3.in_ready", 32'(rdy3), 32'(1));
    tick();
    chk("good3.out_valid", 32'(ov3), 32'(3'b100));
    chk("good3.out_data",  32'(od3), 32'(12'h600));
    chk("good3.err_pulse", 32'(ep3), 32'(0));
    v3 = 0; ordy3 = 3'b111;
    tick();
    chk("good3.drained", 32'(ov3), 32'(0));

    // reset mid-operation discards held words and the offered word
    drive4(1, 0, 1, 4'hE, 4'h0);
    tick();
    chk("fill.out_valid", 32'(ov4), 32'(4'hF));
    chk("fill.out_data",  32'(od4), 32'(16'hEEEE));
    rst = 1'b1;
    drive4(1, 1, 1, 4'h1, 4'h0);
    #1;
    chk("midrst.in_ready", 32'(rdy4), 32'(0));
    tick();
    chk("midrst.out_valid", 32'(ov4), 32'(0));
    chk("midrst.out_data",  32'(od4), 32'(0));
    chk("midrst.err_cnt",   32'(ec4), 32'(0));
    chk("midrst.err_cnt3",  32'(ec3), 32'(0));
    rst = 1'b0;
    drive4(0, 0, 0, 4'h0, 4'h0);
    #1;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive4($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 4) == 0, 4'($urandom), 4'($urandom));
      #1;
      cmp_model($sformatf("rnd%0d", n));
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1ton_stream.md
Name: demux_1toN_stream

Overview:
- Parametrised 1-to-NCH stream demultiplexer with a valid/ready handshake and one registered holding slot per output channel.
- Routes each accepted input word to the channel chosen by in_sel, or to all channels in broadcast mode.
- Flags and counts words addressed to a non-existent channel.
- Sits between a single producer and NCH independent consumers that may each stall.

Parameters:
- WIDTH, 4, data word width in bits
- NCH, 4, number of output channels (2..16)
- SELW, $clog2(NCH) (minimum 1), width of in_sel
- CNTW, 8, width of the saturating error counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  input word
- in_sel  input  SELW  destination channel index
- in_bcast  input  1  when 1, the word goes to all channels and in_sel is ignored
- out_valid  output  NCH  per-channel slot holds a word
- out_ready  input  NCH  per-channel consumer accepts
- out_data  output  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- err_pulse  output  1  single-cycle pulse when a word is dropped for a bad in_sel
- err_cnt  output  CNTW  saturating count of dropped words

Behaviour:
- Reset:
  - Clocked on clk with a synchronous, active-high rst.
  - While rst=1, all slots empty: out_valid=0, out_data=0, err_pulse=0, err_cnt=0, in_ready=0.
  - A reset asserted mid-operation discards all held words immediately at the next edge.
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer on channel i: out_valid[i] & out_ready[i].
- Slot can_accept[i] = !out_valid[i] | out_ready[i]. A slot is refilled in the same cycle it drains, with no bubble.
- in_ready is combinational, with no dependence on in_valid:
  - bcast=1: AND of can_accept over all channels.
  - bcast=0 and in_sel<NCH: can_accept[in_sel].
  - bcast=0 and in_sel>=NCH: 1, so the word is always accepted and dropped.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k, i.e. exactly 1 cycle.
- Slot update at each edge, per channel i:
  - If loaded: out_data[i] <= in_data, out_valid[i] <= 1.
  - Else if drained: out_valid[i] <= 0, out_data[i] <= 0.
  - Else: hold.
  - Loaded means an input transfer with (bcast | in_sel==i).
- out_data for an empty slot is always 0, so inactive outputs read zero.
- Broadcast is all-or-nothing: no partial delivery. The word waits until every slot can accept.
- Bad select (bcast=0, in_sel>=NCH; only possible when NCH is not a power of 2):
  - The word is consumed and no slot changes.
  - err_pulse=1 for the following cycle (registered).
  - err_cnt increments, saturating at 2^CNTW-1 with no wrap.
- A stalled channel never blocks transfers to other channels (no head-of-line blocking, except in broadcast).
- out_ready on an empty slot has no effect.
- Changing in_sel or in_data while in_valid=1 and in_ready=0 is legal. The block samples only at the transfer edge.
- No combinational path from out_ready to out_valid/out_data. The only path out_ready -> in_ready is via can_accept.

Decomposition:
- Package demux_pkg holds:
  - function clog2_min1
  - localparam CNT_MAX helper
- Sub-module demux_slot (WIDTH): one-entry holding register with inputs load, data, ready and outputs valid, data, can_accept.
- The top instantiates NCH slots in a generate loop and holds the select decode, broadcast AND, and error counter.

Test Plan:
- Basic routing (WIDTH=4, NCH=4): reset, then send 4'hA to sel=2 with all out_ready=1.
  - out_valid=4'b0100 and out_data[11:8]=4'hA one cycle later.
  - Other lanes read 0; the slot empties on the next cycle.
- Stall isolation: out_ready[1]=0, send 4'h3 to ch1 then 4'h5 to ch1 then 4'h7 to ch0.
  - in_ready=0 while ch1 is full (second word held).
  - ch0 receives 4'h7 only after the second ch1 word is accepted; ch1 keeps 4'h3 until out_ready[1]=1.
- Back-to-back throughput: sel=3, out_ready[3]=1, 8 consecutive words 0..7.
  - in_ready stays 1 throughout.
  - Channel 3 outputs 0..7 on consecutive cycles, one-cycle delayed.
- Broadcast: out_ready=4'b1011 with slot 2 full, bcast=1 data 4'hC.
  - in_ready=0 until out_ready[2] rises.
  - All four lanes then show 4'hC simultaneously.
- Bad select (NCH=3, SELW=2): send sel=3 three times.
  - in_ready=1 each time; no out_valid change.
  - err_pulse pulses 3 times; err_cnt=3.
  - With CNTW=2, a further send keeps err_cnt at 3.
- Reset mid-operation: fill all slots, assert rst for 1 cycle with in_valid=1.
  - Next cycle out_valid=0, out_data=0, err_cnt=0, and the offered word is not captured.
